// File: rtl/xgmii_pkg.sv
// Shared XGMII definitions for the TX frame generator and the matching RX checker.
// Contents:
//   - XGMII control characters
//   - the idle and start words
//   - the generator state type
//   - a helper that builds one word of the incrementing payload
package xgmii_pkg;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] PREAMBLE    = 8'h55;
  localparam logic [7:0] SFD         = 8'hD5;

  localparam logic [63:0] IDLE_WORD  = {8{XGMII_IDLE}};
  // Lane0 carries START, lanes 1-6 carry preamble, and lane7 carries SFD.
  localparam logic [63:0] START_WORD = {SFD, {6{PREAMBLE}}, XGMII_START};
  localparam logic [7:0]  START_CTRL = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_TERM,
    ST_IFG,
    ST_HOLD
  } gen_state_t;

  // Builds an incrementing-pattern word whose lane0 byte equals base.
  // Only the low 8 bits of the byte index matter, because the byte values wrap mod 256.
  function automatic logic [63:0] inc_word(input logic [7:0] base);
    logic [63:0] w;
    w = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      w[8*i +: 8] = base + 8'(i);
    end
    return w;
  endfunction

endpackage

// File: rtl/xgmii_term_encode.sv
// Combinational encoder for the XGMII word that carries the terminate character.
// Lane layout:
//   - Lanes below r carry data bytes from the low lanes of data, with txc clear.
//   - Lane r carries FD.
//   - Lanes above r carry idle (07).
//   - Every lane from r upward has txc set.
// When r = 0, the output is the standalone 07..07FD terminate word.
// Ports:
//   r    - number of data bytes in the word (0..7)
//   data - source word for the data lanes
//   txd  - encoded XGMII data
//   txc  - encoded XGMII control
module xgmii_term_encode
  import xgmii_pkg::*;
(
  input  logic [2:0]  r,
  input  logic [63:0] data,
  output logic [63:0] txd,
  output logic [7:0]  txc
);

  always_comb begin
    txd = IDLE_WORD;
    txc = '1;
    for (int unsigned i = 0; i < 8; i++) begin
      if (3'(i) < r) begin
        txd[8*i +: 8] = data[8*i +: 8];
        txc[i]        = 1'b0;
      end else if (3'(i) == r) begin
        txd[8*i +: 8] = XGMII_TERM;
      end
    end
  end

endmodule

// File: rtl/xgmii_frame_gen.sv
// XGMII TX frame source for PHY bring-up, loopback and BER soak runs.
// Each frame has three parts:
//   - a start/preamble/SFD word
//   - a payload of cfg_payload_len bytes, either incrementing or a fixed word (no FCS)
//   - a correctly placed terminate
// A programmable idle gap follows every frame.
// Ports:
//   tx_clk, tx_rst_n  - clock and asynchronous active-low reset
//   cfg_enable        - level; 1 = generate frames
//   cfg_payload_len   - payload bytes per frame; values below 8 act as 8
//   cfg_ifg_words     - idle words after each terminate; 0 acts as 1
//   cfg_pattern_sel   - 0 = incrementing bytes, 1 = cfg_fixed_word
//   cfg_fixed_word    - fixed payload word
//   cfg_frame_limit   - frames per enable; 0 = continuous
//   xgmii_txd/txc     - registered XGMII outputs; lane0 = bits 7:0
//   busy              - high outside IDLE
//   done              - one-cycle pulse when the frame limit is reached
//   frames_sent       - wrapping count of terminated frames
module xgmii_frame_gen
  import xgmii_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  tx_clk,
  input  logic                  tx_rst_n,
  input  logic                  cfg_enable,
  input  logic [15:0]           cfg_payload_len,
  input  logic [3:0]            cfg_ifg_words,
  input  logic                  cfg_pattern_sel,
  input  logic [DATA_WIDTH-1:0] cfg_fixed_word,
  input  logic [CNT_WIDTH-1:0]  cfg_frame_limit,
  output logic [DATA_WIDTH-1:0] xgmii_txd,
  output logic [CTRL_WIDTH-1:0] xgmii_txc,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  frames_sent
);

  gen_state_t state_q, state_d;

  // Config latched at frame start.
  logic [15:0]           len_q;
  logic [3:0]            ifg_q;
  logic                  pat_q;
  logic [DATA_WIDTH-1:0] fixed_q;
  logic [CNT_WIDTH-1:0]  limit_q;

  logic [15:0]           len_in;
  logic [3:0]            ifg_in;

  logic [15:0]           bytes_q, bytes_d, rem;
  logic [3:0]            ifg_cnt_q, ifg_cnt_d;
  logic                  fd_pend_q, fd_pend_d;
  logic [CNT_WIDTH-1:0]  run_cnt_q;

  logic                  latch, run_clr, frame_inc, done_d;
  logic [DATA_WIDTH-1:0] data_word, txd_d, te_txd;
  logic [CTRL_WIDTH-1:0] txc_d, te_txc;
  logic [2:0]            te_r;

  assign len_in    = (cfg_payload_len < 16'd8) ? 16'd8 : cfg_payload_len;
  assign ifg_in    = (cfg_ifg_words == 4'd0) ? 4'd1 : cfg_ifg_words;
  assign rem       = len_q - bytes_q;
  assign data_word = pat_q ? fixed_q : inc_word(bytes_q[7:0]);

  // Once a full final word has gone out, the pending flag forces r = 0.
  // That makes the encoder produce the standalone FD word.
  assign te_r = fd_pend_q ? 3'd0 : len_q[2:0];

  xgmii_term_encode u_term_encode (
    .r    (te_r),
    .data (data_word),
    .txd  (te_txd),
    .txc  (te_txc)
  );

  // The next-state logic also chooses the word for the state being entered.
  // That word is registered together with the state.
  always_comb begin
    state_d   = state_q;
    txd_d     = IDLE_WORD;
    txc_d     = '1;
    done_d    = 1'b0;
    bytes_d   = bytes_q;
    ifg_cnt_d = ifg_cnt_q;
    fd_pend_d = fd_pend_q;
    latch     = 1'b0;
    run_clr   = 1'b0;
    frame_inc = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_enable) begin
          state_d = ST_START;
          txd_d   = START_WORD;
          txc_d   = START_CTRL;
          bytes_d = '0;
          latch   = 1'b1;
          run_clr = 1'b1;
        end
      end

      ST_START, ST_DATA: begin
        if (rem > 16'd8) begin
          state_d = ST_DATA;
          txd_d   = data_word;
          txc_d   = '0;
          bytes_d = bytes_q + 16'd8;
        end else begin
          state_d = ST_TERM;
          if (len_q[2:0] == 3'd0) begin
            txd_d     = data_word;
            txc_d     = '0;
            fd_pend_d = 1'b1;
          end else begin
            txd_d     = te_txd;
            txc_d     = te_txc;
            frame_inc = 1'b1;
          end
        end
      end

      ST_TERM: begin
        if (fd_pend_q) begin
          txd_d     = te_txd;
          txc_d     = te_txc;
          fd_pend_d = 1'b0;
          frame_inc = 1'b1;
        end else begin
          state_d   = ST_IFG;
          ifg_cnt_d = 4'd1;
        end
      end

      ST_IFG: begin
        if (ifg_cnt_q >= ifg_q) begin
          if ((limit_q != '0) && (run_cnt_q == limit_q)) begin
            state_d = ST_HOLD;
            done_d  = 1'b1;
          end else if (cfg_enable) begin
            state_d = ST_START;
            txd_d   = START_WORD;
            txc_d   = START_CTRL;
            bytes_d = '0;
            latch   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          ifg_cnt_d = ifg_cnt_q + 4'd1;
        end
      end

      ST_HOLD: begin
        if (!cfg_enable) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      state_q     <= ST_IDLE;
      bytes_q     <= '0;
      ifg_cnt_q   <= '0;
      fd_pend_q   <= 1'b0;
      run_cnt_q   <= '0;
      frames_sent <= '0;
      xgmii_txd   <= IDLE_WORD;
      xgmii_txc   <= '1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q   <= state_d;
      bytes_q   <= bytes_d;
      ifg_cnt_q <= ifg_cnt_d;
      fd_pend_q <= fd_pend_d;
      xgmii_txd <= txd_d;
      xgmii_txc <= txc_d;
      busy      <= (state_d != ST_IDLE);
      done      <= done_d;
      if (frame_inc) frames_sent <= frames_sent + CNT_WIDTH'(1);
      if (run_clr) begin
        run_cnt_q <= '0;
      end else if (frame_inc) begin
        run_cnt_q <= run_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      len_q   <= 16'd8;
      ifg_q   <= 4'd1;
      pat_q   <= 1'b0;
      fixed_q <= '0;
      limit_q <= '0;
    end else if (latch) begin
      len_q   <= len_in;
      ifg_q   <= ifg_in;
      pat_q   <= cfg_pattern_sel;
      fixed_q <= cfg_fixed_word;
      limit_q <= cfg_frame_limit;
    end
  end

endmodule

// File: tb/tb_xgmii_frame_gen.sv
// Self-checking bench for xgmii_frame_gen.
// Each expected XGMII word is pushed to a scoreboard queue together with:
//   - busy
//   - done
//   - frames_sent
// It is pushed when the stimulus that causes it is applied.
// Each cycle, #1 after the rising edge, one entry is popped and compared.
// A table of frame configurations is also checked against the observed word count
// and the terminate control byte.
module tb_xgmii_frame_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_enable;
  logic [15:0] cfg_payload_len;
  logic [3:0]  cfg_ifg_words;
  logic        cfg_pattern_sel;
  logic [63:0] cfg_fixed_word;
  logic [31:0] cfg_frame_limit;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;
  logic        busy;
  logic        done;
  logic [31:0] frames_sent;

  always #5 clk = ~clk;

  xgmii_frame_gen #(
    .DATA_WIDTH (64),
    .CTRL_WIDTH (8),
    .CNT_WIDTH  (32)
  ) dut (
    .tx_clk          (clk),
    .tx_rst_n        (rst_n),
    .cfg_enable      (cfg_enable),
    .cfg_payload_len (cfg_payload_len),
    .cfg_ifg_words   (cfg_ifg_words),
    .cfg_pattern_sel (cfg_pattern_sel),
    .cfg_fixed_word  (cfg_fixed_word),
    .cfg_frame_limit (cfg_frame_limit),
    .xgmii_txd       (xgmii_txd),
    .xgmii_txc       (xgmii_txc),
    .busy            (busy),
    .done            (done),
    .frames_sent     (frames_sent)
  );

  typedef struct {
    logic [63:0] txd;
    logic [7:0]  txc;
    logic        busy;
    logic        done;
    logic [31:0] fs;
  } exp_t;

  typedef struct {
    int          len;
    int          ifg;
    logic        pat;
    logic [63:0] fx;
    int          limit;
    int          words;     // words from START through the FD word
    logic [7:0]  term_txc;  // txc of the word carrying FD
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[6];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_fs = '0;
  int          cur_words = 0;
  int          obs_words = 0;
  logic [7:0]  obs_txc = '0;

  localparam logic [63:0] T_IDLE  = 64'h0707070707070707;
  localparam logic [63:0] T_START = 64'hD5555555555555FB;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [63:0] d, input logic [7:0] c, input logic b, input logic dn);
    exp_t e;
    e.txd  = d;
    e.txc  = c;
    e.busy = b;
    e.done = dn;
    e.fs   = exp_fs;
    sb.push_back(e);
  endtask

  task automatic push_idles(input int n, input logic b);
    for (int i = 0; i < n; i++) push(T_IDLE, 8'hFF, b, 1'b0);
  endtask

  function automatic logic [7:0] dbyte(input int k, input logic pat, input logic [63:0] fx);
    logic [7:0] v;
    v = pat ? fx[8*(k%8) +: 8] : k[7:0];
    return v;
  endfunction

  // Reference frame: START, full payload words, then the FD-bearing word.
  task automatic push_frame(input int len, input logic pat, input logic [63:0] fx);
    int          l;
    int          r;
    logic [63:0] w;
    logic [7:0]  c;
    l = (len < 8) ? 8 : len;
    push(T_START, 8'h01, 1'b1, 1'b0);
    for (int k = 0; k < l / 8; k++) begin
      for (int i = 0; i < 8; i++) w[8*i +: 8] = dbyte(k*8 + i, pat, fx);
      push(w, 8'h00, 1'b1, 1'b0);
    end
    r = l % 8;
    w = T_IDLE;
    c = 8'hFF;
    for (int i = 0; i < r; i++) begin
      w[8*i +: 8] = dbyte((l/8)*8 + i, pat, fx);
      c[i] = 1'b0;
    end
    w[8*r +: 8] = 8'hFD;
    exp_fs++;
    push(w, c, 1'b1, 1'b0);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("stream{txd,txc,busy,done,frames}",
          {xgmii_txd, xgmii_txc, busy, done, frames_sent},
          {e.txd, e.txc, e.busy, e.done, e.fs});
    if (xgmii_txc == 8'h01 && xgmii_txd[7:0] == 8'hFB) cur_words = 1;
    else cur_words++;
    for (int i = 0; i < 8; i++) begin
      if (xgmii_txc[i] && xgmii_txd[8*i +: 8] == 8'hFD) begin
        obs_words = cur_words;
        obs_txc   = xgmii_txc;
      end
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 4000) begin
      step();
      guard++;
    end
    check("drain_empty", 128'(sb.size()), 128'(0));
  endtask

  task automatic set_cfg(input int len, input int ifg, input logic pat, input logic [63:0] fx,
                         input int limit);
    cfg_payload_len = 16'(len);
    cfg_ifg_words   = 4'(ifg);
    cfg_pattern_sel = pat;
    cfg_fixed_word  = fx;
    cfg_frame_limit = 32'(limit);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{len: 64, ifg: 1,  pat: 1'b0, fx: 64'h0,                limit: 1, words: 10, term_txc: 8'hFF};
    vecs[1] = '{len: 61, ifg: 2,  pat: 1'b1, fx: 64'hCAFEBABECAFEBABE, limit: 1, words: 9,  term_txc: 8'hE0};
    vecs[2] = '{len: 3,  ifg: 0,  pat: 1'b0, fx: 64'h0,                limit: 1, words: 3,  term_txc: 8'hFF};
    vecs[3] = '{len: 9,  ifg: 3,  pat: 1'b0, fx: 64'h0,                limit: 1, words: 3,  term_txc: 8'hFE};
    vecs[4] = '{len: 15, ifg: 1,  pat: 1'b1, fx: 64'h0123456789ABCDEF, limit: 1, words: 3,  term_txc: 8'h80};
    vecs[5] = '{len: 20, ifg: 15, pat: 1'b0, fx: 64'h0,                limit: 2, words: 4,  term_txc: 8'hF0};

    rst_n      = 1'b0;
    cfg_enable = 1'b0;
    set_cfg(0, 0, 1'b0, 64'h0, 0);

    // Reset values, then idle with enable low.
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {xgmii_txd, xgmii_txc, busy, done, frames_sent},
          {T_IDLE, 8'hFF, 1'b0, 1'b0, 32'h0});
    rst_n = 1'b1;
    push_idles(3, 1'b0);
    drain();

    // Table-driven single-run frames ending in HOLD.
    for (int v = 0; v < 6; v++) begin
      set_cfg(vecs[v].len, vecs[v].ifg, vecs[v].pat, vecs[v].fx, vecs[v].limit);
      cfg_enable = 1'b1;
      obs_words  = 0;
      obs_txc    = '0;
      for (int f = 0; f < vecs[v].limit; f++) begin
        push_frame(vecs[v].len, vecs[v].pat, vecs[v].fx);
        push_idles((vecs[v].ifg == 0) ? 1 : vecs[v].ifg, 1'b1);
      end
      push(T_IDLE, 8'hFF, 1'b1, 1'b1);
      push(T_IDLE, 8'hFF, 1'b1, 1'b0);
      drain();
      cfg_enable = 1'b0;
      push(T_IDLE, 8'hFF, 1'b0, 1'b0);
      drain();
      check($sformatf("vec%0d_words", v), 128'(obs_words), 128'(vecs[v].words));
      check($sformatf("vec%0d_term_txc", v), 128'(obs_txc), 128'(vecs[v].term_txc));
    end

    // Continuous mode; a mid-frame length change only applies from the next frame.
    set_cfg(3, 0, 1'b0, 64'h0, 0);
    cfg_enable = 1'b1;
    push_frame(3, 1'b0, 64'h0);
    step();
    cfg_payload_len = 16'd16;
    drain();
    push_idles(1, 1'b1);
    push_frame(16, 1'b0, 64'h0);
    step();
    step();
    cfg_enable = 1'b0;
    push_idles(1, 1'b1);
    push(T_IDLE, 8'hFF, 1'b0, 1'b0);
    drain();

    // Enable dropped during a long frame: the frame still terminates and observes its gap.
    set_cfg(1500, 2, 1'b0, 64'h0, 0);
    cfg_enable = 1'b1;
    obs_words  = 0;
    obs_txc    = '0;
    push_frame(1500, 1'b0, 64'h0);
    repeat (5) step();
    cfg_enable = 1'b0;
    push_idles(2, 1'b1);
    push(T_IDLE, 8'hFF, 1'b0, 1'b0);
    drain();
    check("long_words", 128'(obs_words), 128'(189));
    check("long_term_txc", 128'(obs_txc), 128'(8'hF0));

    // Reset in the middle of DATA.
    set_cfg(64, 1, 1'b0, 64'h0, 0);
    cfg_enable = 1'b1;
    push_frame(64, 1'b0, 64'h0);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("midrst_async", {xgmii_txd, xgmii_txc, busy, done, frames_sent},
          {T_IDLE, 8'hFF, 1'b0, 1'b0, 32'h0});
    @(posedge clk);
    #1;
    check("midrst_edge", {xgmii_txd, xgmii_txc, busy, done, frames_sent},
          {T_IDLE, 8'hFF, 1'b0, 1'b0, 32'h0});
    sb.delete();
    exp_fs = '0;
    rst_n  = 1'b1;
    push_frame(64, 1'b0, 64'h0);
    step();
    step();
    cfg_enable = 1'b0;
    push_idles(1, 1'b1);
    push(T_IDLE, 8'hFF, 1'b0, 1'b0);
    drain();
    check("post_rst_frames", 128'(frames_sent), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/xgmii_frame_gen.md
Name: xgmii_frame_gen

Overview:
- Synthesisable XGMII frame source sitting directly upstream of eth_phy_10g on the TX side; drives xgmii_txd/xgmii_txc.
- Emits start/preamble/SFD, a configurable-length payload (incrementing or fixed pattern), a correctly positioned terminate, and a programmable inter-frame gap.
- No FCS is generated; the payload is opaque.
- Used for PHY bring-up, loopback and BER soak runs.

Parameters:
- DATA_WIDTH, 64, XGMII data width; only 64 is supported.
- CTRL_WIDTH, 8, XGMII control width; must equal DATA_WIDTH/8.
- CNT_WIDTH, 32, width of frames_sent and cfg_frame_limit.

Ports:
- tx_clk  in  1  XGMII TX clock; everything is in this domain.
- tx_rst_n  in  1  asynchronous, active-low reset.
- cfg_enable  in  1  level; 1 = generate frames.
- cfg_payload_len  in  16  payload bytes per frame; values below 8 are clamped to 8.
- cfg_ifg_words  in  4  idle words after each terminate; 0 is treated as 1.
- cfg_pattern_sel  in  1  0 = incrementing bytes, 1 = cfg_fixed_word repeated.
- cfg_fixed_word  in  64  fixed payload word.
- cfg_frame_limit  in  CNT_WIDTH  frames per enable; 0 = continuous.
- xgmii_txd  out  64  XGMII data; lane0 = bits 7:0.
- xgmii_txc  out  8  XGMII control; bit i = lane i.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when cfg_frame_limit frames have been sent.
- frames_sent  out  CNT_WIDTH  terminated-frame counter; wraps.

Behaviour:
- Reset (async assert, sync release): xgmii_txd = 64'h0707070707070707, xgmii_txc = 8'hFF, busy = 0, done = 0, frames_sent = 0, state = IDLE. All outputs are registered.
- States: IDLE, START, DATA, TERM, IFG, HOLD.
- IDLE: drive idle words. If cfg_enable = 1, latch len, ifg, pattern, fixed word and limit, then go to START. The START word appears on the cycle after the cycle in which enable is sampled high.
- START: txd = 64'hD5555555555555FB, txc = 8'h01. Go to DATA, or to TERM when len = 8.
- DATA: one 8-byte word per cycle, txc = 8'h00. Track rem_bytes = len - bytes sent.
  - Stay while rem_bytes > 8.
  - At rem_bytes <= 8, emit the final data word in the TERM state.
- Incrementing pattern: byte value = (payload byte index) mod 256, restarting at 0x00 each frame; lane0 carries the lowest index.
- Fixed pattern: cfg_fixed_word is emitted every word; the final partial word uses its low lanes.
- TERM, with r = len mod 8:
  - r != 0: lanes 0..r-1 carry data with txc = 0; lane r = FD; lanes above r = 07; txc = ~((1<<r)-1) & 8'hFF.
  - r = 0: the last full data word (txc = 0) is emitted, then a separate word 64'h07070707070707FD with txc = 8'hFF.
  - frames_sent increments on the cycle the FD word is output.
- IFG: emit max(cfg_ifg_words, 1) idle words. Then:
  - if limit != 0 and frames in this run == limit: pulse done, go to HOLD;
  - else if cfg_enable = 1: relatch config, go to START;
  - else go to IDLE.
- HOLD: idle words; stay until cfg_enable = 0, then go to IDLE. This prevents the limit from re-arming.
- cfg_enable deasserted mid-frame: the current frame completes, including terminate and IFG. No truncated frame is ever produced.
- cfg_* changes mid-frame have no effect until the next frame start.
- frames_sent wraps from all-ones to 0 with no flag.
- tx_rst_n asserted mid-frame: outputs go to idle immediately. The PHY sees an unterminated frame; this is accepted behaviour.

Decomposition:
- Package xgmii_pkg holds:
  - constants XGMII_IDLE = 8'h07, XGMII_START = 8'hFB, XGMII_TERM = 8'hFD, PREAMBLE = 8'h55, SFD = 8'hD5;
  - IDLE_WORD = 64'h0707070707070707;
  - the state enum.
- One combinational sub-module, xgmii_term_encode: inputs r[2:0] and data[63:0]; outputs txd/txc for the TERM word. It is reused by the future RX checker for expected-value generation.

Test Plan:
- Reset held, then released with cfg_enable = 0 -> txd = 0707070707070707 and txc = FF on every cycle; busy = 0.
- len = 64, incrementing, ifg = 1, limit = 1 -> START word FB..D5; 8 data words with the first = 0706050403020100; word 07070707070707FD with txc = FF; done pulse; frames_sent = 1; then HOLD.
- len = 61, fixed = CAFEBABECAFEBABE -> 7 full words; TERM word lanes 0-4 = BE BA FE CA BE, lane5 = FD, lanes 6-7 = 07, txc = E0.
- len = 3 (clamped to 8), ifg = 0 -> START, TERM r = 0 path, exactly 1 idle word between frames; continuous operation.
- cfg_enable dropped during DATA of a len = 1500 frame -> frame terminates normally (r = 4, txc = F0); IFG; IDLE; frames_sent += 1.
- tx_rst_n pulsed low mid-DATA -> next edge shows an idle word; frames_sent = 0; after release with enable high, a new START follows on the second cycle.
